axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Sequential arbiter that shares the single AXI read channel (AR/R) of the CPU core between the instruction cache and the data cache. It grants one requester at a time, registers the AR fields, holds ownership for the whole burst until the last R beat, and routes R beats back only to the owner. It sits between the two cache read ports and the core's AXI master interface, and has no write-channel involvement.

## Interface
- `INST_ID`, 4'd0: AXI `arid` used for instruction-cache transactions.
- `DATA_ID`, 4'd1: AXI `arid` used for data-cache transactions.
- `aclk`  in  1  clock; all logic is rising-edge.
- `aresetn`  in  1  reset; **one clock, asynchronous active-low reset**.
- `inst_arvalid`  in  1  inst cache read request; held high until `inst_arready`.
- `inst_araddr`  in  32  inst request address.
- `inst_arlen`  in  8  inst beats minus 1 (8'h0f for a line, 8'h00 for uncached).
- `inst_arready`  out  1  one-cycle pulse on the AXI AR handshake of the inst transaction.
- `inst_rdata`  out  32  routed read data.
- `inst_rvalid`  out  1  routed beat valid.
- `inst_rlast`  out  1  routed last beat.
- `data_arvalid`, `data_araddr`, `data_arlen`, `data_arready`, `data_rdata`, `data_rvalid`, `data_rlast`: same as the inst_* ports, for the data cache.
- `arid` 4, `araddr` 32, `arlen` 8, `arsize` 3, `arburst` 2, `arlock` 2, `arcache` 4, `arprot` 3, `arvalid` 1  out: AXI AR master.
- `arready`  in  1  AXI AR slave ready.
- `rid` 4, `rdata` 32, `rresp` 2, `rlast` 1, `rvalid` 1  in: AXI R.
- `rready`  out  1  AXI R ready.
- `rlast_err`  out  1  sticky flag; beat count and `rlast` disagreed.

## Operation
- States: IDLE, AR, R.
- **IDLE**
  - Sample both `*_arvalid`.
  - If only one is high, grant it.
  - If both are high, grant the requester that was not served last. The round-robin pointer resets to "data first".
  - On grant, latch `owner`, `araddr`, `arlen`, and `arid` (INST_ID or DATA_ID). Clear the beat counter. Go to AR.
- **AR**
  - `arvalid`=1 from registers. Outputs stay stable until `arready`.
  - On `arvalid & arready`: pulse the owner's `*_arready` in that same cycle, go to R, and flip the round-robin pointer to the other requester.
- **R**
  - `rready`=1.
  - Routing: `owner_rvalid = rvalid & (rid==arid_q)`, `owner_rdata = rdata`, `owner_rlast = rlast`.
  - The beat counter increments on each accepted beat.
  - On an accepted beat with `rlast`, go to IDLE.
  - If `rlast` arrives while counter != `arlen_q`, or counter == `arlen_q` without `rlast`, set `rlast_err`. The cleared transaction still ends on `rlast`.
- The non-owner always sees `rvalid`=0, `rlast`=0, `rdata`=32'h0. In IDLE/AR both requesters see zero.
- Fixed AR fields:
  - `arsize`=3'b010.
  - `arburst`=2'b01 (INCR) if `arlen_q`!=0, else 2'b00.
  - `arlock`=0, `arcache`=0, `arprot`=0.
- The beat counter is 8 bits and is compared to `arlen_q`. It never wraps within a legal burst (max 256 beats).
- `rresp` is ignored. Error handling belongs to the caches.

## Timing
- Reset (async, any state):
  - State IDLE.
  - `arvalid`, `rready`, `*_arready`, `*_rvalid`, `*_rlast`, and `rlast_err` all 0.
  - `araddr`/`arlen`/`arid` registers 0.
  - Round-robin pointer is data.
  - Any burst in flight is abandoned.
- Cycle-level sequence:
  - A request sampled in IDLE at edge N gives `arvalid`=1 from cycle N+1 (one-cycle grant latency).
  - The AR handshake in cycle M gives `rready`=1 from M+1.
  - The last beat accepted in cycle K returns the block to IDLE in K+1, and a new grant registers at K+1. This is one mandatory bubble between transactions.
- Routing of R beats is combinational, with zero latency from AXI R to the owner port.
- A requester that drops `*_arvalid` after being granted is ignored. The latched transaction completes, and its beats still go to that port.
- `arready` already high when `arvalid` rises: the handshake completes in the first AR cycle.

## Structure
- The shared header `axi_arb_defs.vh` (included like `cache_config.vh`) holds:
  - state encodings (IDLE=2'd0, AR=2'd1, R=2'd2),
  - INST_ID/DATA_ID defaults,
  - AXI constants: SIZE_4B, BURST_FIXED, BURST_INCR.
- Single flat module. The beat counter plus `rlast_err` check is kept inline; no sub-module is needed.
- Expected size: about 150–200 lines.

## Test plan
- **Inst only:** inst request, addr 0xBFC0_0000, len 0x0f. Expect `arvalid`=1 one cycle later with `arid`=0, `arburst`=01, `arlen`=0x0f. Expect 16 beats routed to the inst port only, `inst_rlast` on beat 16, IDLE next cycle, `rlast_err`=0.
- **Data uncached:** len 0. Expect `arburst`=00 and a single beat to the data port. The inst port stays all-zero throughout.
- **Simultaneous requests after reset:** data is granted first. After its `rlast`, inst is granted with exactly one idle cycle in between.
- **Back-to-back contention:** both requesters continuously requesting. Grants alternate data, inst, data, inst over four transactions.
- **AR backpressure:** hold `arready`=0 for 5 cycles. Expect `araddr`/`arlen`/`arid` stable, then a single-cycle `*_arready` pulse.
- **Error and reset:** `rlast` on beat 3 of a len-0x0f burst sets `rlast_err`=1, which stays high until reset. Asserting `aresetn`=0 mid-burst forces `arvalid`/`rready`/`rlast_err` to 0 asynchronously and returns the state to IDLE.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared state, owner and AXI AR encodings for the I/D-cache read-channel arbiter.
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Single-beat (uncached) reads go out as FIXED, cache line fills as INCR.
    function automatic logic [1:0] burst_for_len(input logic [7:0] len);
        return (len != 8'h00) ? BURST_INCR : BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Read-port bundles: one cache-side request/response port and the shared AXI AR/R master channel.
interface cache_rd_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;

    modport master (
        output arvalid, araddr, arlen,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen,
        output arready, rdata, rvalid, rlast
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the I-cache and D-cache;
// the winner owns AR and R until the last beat of its burst.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic      aclk,
    input  logic      aresetn,
    cache_rd_if.slave inst,
    cache_rd_if.slave data,
    axi_rd_if.master  axi,
    output logic      rlast_err
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      rr_q, rr_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [3:0]  arid_q, arid_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        rlast_err_q, rlast_err_d;

    owner_e      grant;
    logic        ar_hs;
    logic        inst_own;
    logic        data_own;
    logic        unused_rresp;

    // rr_q names the requester that wins when both ask in the same IDLE cycle.
    always_comb begin
        grant = rr_q;
        if (inst.arvalid && !data.arvalid) begin
            grant = OWN_INST;
        end else if (data.arvalid && !inst.arvalid) begin
            grant = OWN_DATA;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arid_d      = arid_q;
        beat_cnt_d  = beat_cnt_q;
        rlast_err_d = rlast_err_q;

        case (state_q)
            ST_IDLE: begin
                if (inst.arvalid || data.arvalid) begin
                    owner_d    = grant;
                    araddr_d   = (grant == OWN_INST) ? inst.araddr : data.araddr;
                    arlen_d    = (grant == OWN_INST) ? inst.arlen  : data.arlen;
                    arid_d     = (grant == OWN_INST) ? INST_ID     : DATA_ID;
                    beat_cnt_d = 8'h00;
                    state_d    = ST_AR;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    rr_d    = (owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (axi.rvalid) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // rlast must coincide exactly with beat number arlen_q; the burst still ends on rlast.
                    if (axi.rlast != (beat_cnt_q == arlen_q)) begin
                        rlast_err_d = 1'b1;
                    end
                    if (axi.rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_INST;
            rr_q        <= OWN_DATA;
            araddr_q    <= 32'h0;
            arlen_q     <= 8'h00;
            arid_q      <= 4'h0;
            beat_cnt_q  <= 8'h00;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arid_q      <= arid_d;
            beat_cnt_q  <= beat_cnt_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    assign ar_hs    = (state_q == ST_AR) && axi.arready;
    assign inst_own = (state_q == ST_R) && (owner_q == OWN_INST);
    assign data_own = (state_q == ST_R) && (owner_q == OWN_DATA);

    assign axi.arvalid = (state_q == ST_AR);
    assign axi.rready  = (state_q == ST_R);
    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = burst_for_len(arlen_q);
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'h0;
    assign axi.arprot  = 3'h0;

    assign inst.arready = ar_hs && (owner_q == OWN_INST);
    assign data.arready = ar_hs && (owner_q == OWN_DATA);

    // R routing is purely combinational; the non-owner and the IDLE/AR states see all zeros.
    assign inst.rvalid = inst_own && axi.rvalid && (axi.rid == arid_q);
    assign inst.rlast  = inst_own && axi.rlast;
    assign inst.rdata  = inst_own ? axi.rdata : 32'h0;
    assign data.rvalid = data_own && axi.rvalid && (axi.rid == arid_q);
    assign data.rlast  = data_own && axi.rlast;
    assign data.rdata  = data_own ? axi.rdata : 32'h0;

    assign rlast_err = rlast_err_q;

    assign unused_rresp = ^axi.rresp;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus randomized
// contention checked against a round-robin grant model kept in the bench.
module tb_axi_read_arbiter;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic rlast_err;

    cache_rd_if inst_if ();
    cache_rd_if data_if ();
    axi_rd_if   axi_if ();

    axi_read_arbiter #(
        .INST_ID(4'd0),
        .DATA_ID(4'd1)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .inst     (inst_if),
        .data     (data_if),
        .axi      (axi_if),
        .rlast_err(rlast_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Model state: who completed the most recent AR handshake (0 inst, 1 data).
    int last_served = 0;

    int          wc, ip, dp, unst, zb;
    int          ob, obad, othb, rb, li;
    logic [3:0]  gid;
    logic [31:0] gaddr;
    logic [7:0]  glen;
    logic [1:0]  gburst;
    logic [2:0]  gsize;

    function automatic int pick_winner(input bit ireq, input bit dreq);
        if (ireq && dreq) return (last_served == 0) ? 1 : 0;
        return dreq ? 1 : 0;
    endfunction

    function automatic logic [7:0] rand_len();
        case ($urandom_range(2, 0))
            0:       return 8'h00;
            1:       return 8'h0f;
            default: return 8'($urandom_range(7, 1));
        endcase
    endfunction

    task automatic clear_inputs();
        inst_if.arvalid = 1'b0; inst_if.araddr = 32'h0; inst_if.arlen = 8'h0;
        data_if.arvalid = 1'b0; data_if.araddr = 32'h0; data_if.arlen = 8'h0;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0;
        axi_if.rdata = 32'h0; axi_if.rid = 4'h0; axi_if.rresp = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        last_served = 0;
    endtask

    task automatic post_req(input int who, input logic [31:0] addr, input logic [7:0] len);
        if (who == 0) begin
            inst_if.arvalid = 1'b1; inst_if.araddr = addr; inst_if.arlen = len;
        end else begin
            data_if.arvalid = 1'b1; data_if.araddr = addr; data_if.arlen = len;
        end
    endtask

    // Waits for arvalid, records AR fields, holds arready low for 'stall' cycles, then
    // completes the handshake and withdraws the request of whichever port got arready.
    task automatic do_ar(input int stall, output int wait_cyc, output int ipulse, output int dpulse,
                         output int unstable, output int zero_bad, output logic [3:0] id,
                         output logic [31:0] addr, output logic [7:0] len,
                         output logic [1:0] burst, output logic [2:0] size);
        int who;
        wait_cyc = 0; ipulse = 0; dpulse = 0; unstable = 0; zero_bad = 0; who = -1;
        id = 4'h0; addr = 32'h0; len = 8'h0; burst = 2'b00; size = 3'b000;
        axi_if.arready = (stall == 0);
        do begin
            @(negedge aclk); #1;
            wait_cyc++;
        end while (!axi_if.arvalid && wait_cyc < 20);
        if (!axi_if.arvalid) begin
            wait_cyc = -1;
            axi_if.arready = 1'b0;
            return;
        end
        id = axi_if.arid; addr = axi_if.araddr; len = axi_if.arlen;
        burst = axi_if.arburst; size = axi_if.arsize;
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) begin
                axi_if.arready = 1'b1;
                #1;
            end
            if (axi_if.arid !== id || axi_if.araddr !== addr || axi_if.arlen !== len ||
                axi_if.arvalid !== 1'b1) unstable++;
            if (inst_if.arready) begin ipulse++; who = 0; end
            if (data_if.arready) begin dpulse++; who = 1; end
            if ({inst_if.rvalid, inst_if.rlast, data_if.rvalid, data_if.rlast} !== 4'b0 ||
                inst_if.rdata !== 32'h0 || data_if.rdata !== 32'h0) zero_bad++;
            if (s != stall) begin
                @(negedge aclk); #1;
            end
        end
        @(negedge aclk);
        axi_if.arready = 1'b0;
        if (who == 0) inst_if.arvalid = 1'b0;
        if (who == 1) data_if.arvalid = 1'b0;
        #1;
        if (inst_if.arready) ipulse++;
        if (data_if.arready) dpulse++;
    endtask

    // Drives nbeats R beats (rlast on the final one) with random idle gaps and records
    // what the owner and non-owner ports showed.
    task automatic serve_burst(input int nbeats, input int owner, input int max_gap,
                               output int own_beats, output int own_bad, output int other_bad,
                               output int rready_bad, output int last_idx);
        int   gap;
        logic own_rv, own_rl, oth_rv, oth_rl;
        logic [31:0] own_rd, oth_rd;
        own_beats = 0; own_bad = 0; other_bad = 0; rready_bad = 0; last_idx = 0;
        for (int b = 1; b <= nbeats; b++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g <= gap; g++) begin
                if (g == gap) begin
                    axi_if.rvalid = 1'b1;
                    axi_if.rdata  = $urandom;
                    axi_if.rlast  = (b == nbeats);
                    axi_if.rid    = (owner == 1) ? 4'd1 : 4'd0;
                    axi_if.rresp  = 2'($urandom_range(3, 0));
                end else begin
                    axi_if.rvalid = 1'b0; axi_if.rdata = 32'h0; axi_if.rlast = 1'b0;
                end
                #1;
                own_rv = (owner == 1) ? data_if.rvalid : inst_if.rvalid;
                own_rl = (owner == 1) ? data_if.rlast  : inst_if.rlast;
                own_rd = (owner == 1) ? data_if.rdata  : inst_if.rdata;
                oth_rv = (owner == 1) ? inst_if.rvalid : data_if.rvalid;
                oth_rl = (owner == 1) ? inst_if.rlast  : data_if.rlast;
                oth_rd = (owner == 1) ? inst_if.rdata  : data_if.rdata;
                if (own_rv === 1'b1) own_beats++;
                if (own_rv !== axi_if.rvalid || own_rl !== axi_if.rlast || own_rd !== axi_if.rdata)
                    own_bad++;
                if (own_rv === 1'b1 && own_rl === 1'b1) last_idx = b;
                if (oth_rv !== 1'b0 || oth_rl !== 1'b0 || oth_rd !== 32'h0) other_bad++;
                if (axi_if.rready !== 1'b1) rready_bad++;
                @(negedge aclk); #1;
            end
        end
        axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rdata = 32'h0; axi_if.rresp = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        checks++; if ({axi_if.arvalid, axi_if.rready} !== 2'b00) begin
            errors++; $display("FAIL reset_ar_r: arvalid,rready=%b expected 00", {axi_if.arvalid, axi_if.rready}); end
        checks++; if ({inst_if.arready, data_if.arready, inst_if.rvalid, data_if.rvalid,
                       inst_if.rlast, data_if.rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_cache_ports: got %b expected 000000",
                {inst_if.arready, data_if.arready, inst_if.rvalid, data_if.rvalid, inst_if.rlast, data_if.rlast}); end
        checks++; if (rlast_err !== 1'b0) begin
            errors++; $display("FAIL reset_rlast_err: got %b expected 0", rlast_err); end
        checks++; if ({axi_if.araddr, axi_if.arlen, axi_if.arid} !== 44'h0) begin
            errors++; $display("FAIL reset_ar_regs: addr=%h len=%h id=%h expected 0",
                axi_if.araddr, axi_if.arlen, axi_if.arid); end
        @(negedge aclk);
        aresetn = 1'b1;
        last_served = 0;
        @(negedge aclk); #1;
        checks++; if (axi_if.arvalid !== 1'b0) begin
            errors++; $display("FAIL reset_idle_no_req: arvalid=%b expected 0", axi_if.arvalid); end
    endtask

    task automatic test_inst_only();
        do_reset();
        post_req(0, 32'hBFC0_0000, 8'h0f);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if (wc !== 1) begin
            errors++; $display("FAIL inst_grant_latency: got %0d cycles expected 1", wc); end
        checks++; if ({gid, gaddr, glen, gburst, gsize} !== {4'd0, 32'hBFC0_0000, 8'h0f, 2'b01, 3'b010}) begin
            errors++; $display("FAIL inst_ar_fields: id=%h addr=%h len=%h burst=%b size=%b expected 0 bfc00000 0f 01 010",
                gid, gaddr, glen, gburst, gsize); end
        checks++; if (ip !== 1 || dp !== 0 || zb !== 0) begin
            errors++; $display("FAIL inst_arready_pulse: inst=%0d data=%0d zero_bad=%0d expected 1 0 0", ip, dp, zb); end
        last_served = 0;
        serve_burst(16, 0, 1, ob, obad, othb, rb, li);
        checks++; if (ob !== 16 || obad !== 0 || li !== 16) begin
            errors++; $display("FAIL inst_beats: beats=%0d bad=%0d last_at=%0d expected 16 0 16", ob, obad, li); end
        checks++; if (othb !== 0 || rb !== 0) begin
            errors++; $display("FAIL inst_isolation: data_port_nonzero=%0d rready_low=%0d expected 0 0", othb, rb); end
        checks++; if ({axi_if.arvalid, axi_if.rready, rlast_err} !== 3'b000) begin
            errors++; $display("FAIL inst_back_to_idle: arvalid,rready,err=%b expected 000",
                {axi_if.arvalid, axi_if.rready, rlast_err}); end
    endtask

    task automatic test_data_uncached();
        logic [31:0] a;
        do_reset();
        a = {$urandom} & 32'hFFFF_FFFC;
        post_req(1, a, 8'h00);
        do_ar(int'($urandom_range(2, 0)), wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if ({gid, gaddr, glen, gburst} !== {4'd1, a, 8'h00, 2'b00}) begin
            errors++; $display("FAIL data_ar_fields: id=%h addr=%h len=%h burst=%b expected 1 %h 00 00",
                gid, gaddr, glen, gburst, a); end
        checks++; if (ip !== 0 || dp !== 1 || zb !== 0 || unst !== 0) begin
            errors++; $display("FAIL data_arready_pulse: inst=%0d data=%0d zero_bad=%0d unstable=%0d expected 0 1 0 0",
                ip, dp, zb, unst); end
        last_served = 1;
        serve_burst(1, 1, 2, ob, obad, othb, rb, li);
        checks++; if (ob !== 1 || obad !== 0 || li !== 1 || othb !== 0) begin
            errors++; $display("FAIL data_single_beat: beats=%0d bad=%0d last_at=%0d inst_nonzero=%0d expected 1 0 1 0",
                ob, obad, li, othb); end
    endtask

    task automatic test_simultaneous();
        int w;
        do_reset();
        post_req(0, 32'h0000_1000, 8'h01);
        post_req(1, 32'h0000_2000, 8'h03);
        w = pick_winner(1'b1, 1'b1);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if (gid !== ((w == 1) ? 4'd1 : 4'd0) || gaddr !== 32'h0000_2000) begin
            errors++; $display("FAIL simul_first_grant: id=%h addr=%h expected %0d 00002000", gid, gaddr, w); end
        last_served = w;
        serve_burst(4, 1, 1, ob, obad, othb, rb, li);
        checks++; if (ob !== 4 || othb !== 0 || li !== 4) begin
            errors++; $display("FAIL simul_data_burst: beats=%0d inst_nonzero=%0d last_at=%0d expected 4 0 4", ob, othb, li); end
        checks++; if (axi_if.arvalid !== 1'b0) begin
            errors++; $display("FAIL simul_bubble: arvalid=%b in cycle after rlast expected 0", axi_if.arvalid); end
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if (wc !== 1 || gid !== 4'd0 || gaddr !== 32'h0000_1000 || ip !== 1) begin
            errors++; $display("FAIL simul_second_grant: wait=%0d id=%h addr=%h pulse=%0d expected 1 0 00001000 1",
                wc, gid, gaddr, ip); end
        last_served = 0;
        serve_burst(2, 0, 1, ob, obad, othb, rb, li);
        checks++; if (ob !== 2 || obad !== 0 || othb !== 0) begin
            errors++; $display("FAIL simul_inst_burst: beats=%0d bad=%0d data_nonzero=%0d expected 2 0 0", ob, obad, othb); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] req_addr [2];
        logic [7:0]  req_len [2];
        int          order [4];
        do_reset();
        order = '{1, 0, 1, 0};
        for (int r = 0; r < 2; r++) begin
            req_addr[r] = $urandom; req_len[r] = 8'($urandom_range(3, 0));
            post_req(r, req_addr[r], req_len[r]);
        end
        for (int k = 0; k < 4; k++) begin
            if (!inst_if.arvalid) begin
                req_addr[0] = $urandom; req_len[0] = 8'($urandom_range(3, 0));
                post_req(0, req_addr[0], req_len[0]);
            end
            if (!data_if.arvalid) begin
                req_addr[1] = $urandom; req_len[1] = 8'($urandom_range(3, 0));
                post_req(1, req_addr[1], req_len[1]);
            end
            w = pick_winner(1'b1, 1'b1);
            do_ar(int'($urandom_range(1, 0)), wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
            if (wc < 0) begin
                checks++; errors++;
                $display("FAIL b2b_timeout: no arvalid in transaction %0d", k);
                return;
            end
            checks++; if (gid !== order[k][3:0] || gaddr !== req_addr[w] || glen !== req_len[w]) begin
                errors++; $display("FAIL b2b_grant_%0d: id=%h addr=%h len=%h expected %0d %h %h",
                    k, gid, gaddr, glen, order[k], req_addr[w], req_len[w]); end
            last_served = w;
            serve_burst(int'(req_len[w]) + 1, w, 1, ob, obad, othb, rb, li);
            checks++; if (ob !== int'(req_len[w]) + 1 || obad !== 0 || othb !== 0) begin
                errors++; $display("FAIL b2b_burst_%0d: beats=%0d bad=%0d other_nonzero=%0d expected %0d 0 0",
                    k, ob, obad, othb, int'(req_len[w]) + 1); end
        end
        inst_if.arvalid = 1'b0;
        data_if.arvalid = 1'b0;
    endtask

    task automatic test_ar_backpressure();
        logic [31:0] a;
        do_reset();
        a = $urandom;
        post_req(0, a, 8'h07);
        do_ar(5, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if (unst !== 0 || gaddr !== a || glen !== 8'h07 || gid !== 4'd0) begin
            errors++; $display("FAIL bp_stable: unstable=%0d addr=%h len=%h id=%h expected 0 %h 07 0",
                unst, gaddr, glen, gid, a); end
        checks++; if (ip !== 1 || dp !== 0) begin
            errors++; $display("FAIL bp_single_pulse: inst_pulses=%0d data_pulses=%0d expected 1 0", ip, dp); end
        last_served = 0;
        serve_burst(8, 0, 2, ob, obad, othb, rb, li);
        checks++; if (ob !== 8 || obad !== 0 || rb !== 0 || li !== 8) begin
            errors++; $display("FAIL bp_burst: beats=%0d bad=%0d rready_low=%0d last_at=%0d expected 8 0 0 8",
                ob, obad, rb, li); end
    endtask

    task automatic test_missing_rlast();
        do_reset();
        post_req(1, 32'h0000_0040, 8'h00);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        last_served = 1;
        serve_burst(2, 1, 0, ob, obad, othb, rb, li);
        checks++; if (rlast_err !== 1'b1 || ob !== 2 || li !== 2) begin
            errors++; $display("FAIL missing_rlast: err=%b beats=%0d last_at=%0d expected 1 2 2", rlast_err, ob, li); end
        checks++; if ({axi_if.arvalid, axi_if.rready} !== 2'b00) begin
            errors++; $display("FAIL missing_rlast_idle: arvalid,rready=%b expected 00", {axi_if.arvalid, axi_if.rready}); end
    endtask

    task automatic test_error_and_reset();
        int w;
        do_reset();
        post_req(0, 32'h8000_0000, 8'h0f);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        last_served = 0;
        serve_burst(3, 0, 1, ob, obad, othb, rb, li);
        checks++; if (rlast_err !== 1'b1 || li !== 3) begin
            errors++; $display("FAIL early_rlast_err: err=%b last_at=%0d expected 1 3", rlast_err, li); end
        checks++; if ({axi_if.arvalid, axi_if.rready} !== 2'b00) begin
            errors++; $display("FAIL early_rlast_idle: arvalid,rready=%b expected 00", {axi_if.arvalid, axi_if.rready}); end
        post_req(1, 32'h8000_0100, 8'h00);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        last_served = 1;
        serve_burst(1, 1, 0, ob, obad, othb, rb, li);
        checks++; if (rlast_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: err=%b after clean burst expected 1", rlast_err); end
        post_req(1, 32'h8000_0200, 8'h0f);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        last_served = 1;
        axi_if.rvalid = 1'b1; axi_if.rid = 4'd1; axi_if.rlast = 1'b0; axi_if.rdata = $urandom;
        repeat (2) @(negedge aclk);
        #1;
        axi_if.rvalid = 1'b0; axi_if.rdata = 32'h0;
        aresetn = 1'b0;
        #1;
        checks++; if ({axi_if.arvalid, axi_if.rready, rlast_err} !== 3'b000) begin
            errors++; $display("FAIL async_reset: arvalid,rready,err=%b expected 000",
                {axi_if.arvalid, axi_if.rready, rlast_err}); end
        clear_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
        last_served = 0;
        post_req(0, 32'h0000_3000, 8'h00);
        post_req(1, 32'h0000_4000, 8'h00);
        w = pick_winner(1'b1, 1'b1);
        do_ar(0, wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
        checks++; if (wc !== 1 || gid !== ((w == 1) ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL reset_rr_pointer: wait=%0d id=%h expected 1 %0d", wc, gid, w); end
        last_served = w;
        serve_burst(1, w, 0, ob, obad, othb, rb, li);
        inst_if.arvalid = 1'b0;
        data_if.arvalid = 1'b0;
    endtask

    task automatic test_random();
        bit          pend [2];
        logic [31:0] req_addr [2];
        logic [7:0]  req_len [2];
        int          w;
        int          bad_txn;
        do_reset();
        pend = '{0, 0};
        bad_txn = 0;
        for (int t = 0; t < 24; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(1, 0) == 1) begin
                    pend[r] = 1; req_addr[r] = $urandom; req_len[r] = rand_len();
                    post_req(r, req_addr[r], req_len[r]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = int'($urandom_range(1, 0));
                pend[w] = 1; req_addr[w] = $urandom; req_len[w] = rand_len();
                post_req(w, req_addr[w], req_len[w]);
            end
            w = pick_winner(pend[0], pend[1]);
            do_ar(int'($urandom_range(3, 0)), wc, ip, dp, unst, zb, gid, gaddr, glen, gburst, gsize);
            if (wc < 0) begin
                checks++; errors++;
                $display("FAIL rand_timeout: no arvalid in transaction %0d", t);
                return;
            end
            checks++; if (wc !== 1 || gid !== ((w == 1) ? 4'd1 : 4'd0) || gaddr !== req_addr[w] ||
                          glen !== req_len[w] || gburst !== ((req_len[w] != 0) ? 2'b01 : 2'b00) ||
                          gsize !== 3'b010 || unst !== 0 || zb !== 0 ||
                          ip !== ((w == 0) ? 1 : 0) || dp !== ((w == 1) ? 1 : 0)) begin
                errors++; bad_txn++;
                $display("FAIL rand_ar_%0d: wait=%0d id=%h addr=%h len=%h burst=%b pulses=%0d/%0d expected 1 %0d %h %h",
                    t, wc, gid, gaddr, glen, gburst, ip, dp, w, req_addr[w], req_len[w]);
            end
            last_served = w;
            pend[w] = 0;
            serve_burst(int'(req_len[w]) + 1, w, 2, ob, obad, othb, rb, li);
            checks++; if (ob !== int'(req_len[w]) + 1 || obad !== 0 || othb !== 0 || rb !== 0 ||
                          li !== int'(req_len[w]) + 1 || rlast_err !== 1'b0 ||
                          axi_if.arvalid !== 1'b0 || axi_if.rready !== 1'b0) begin
                errors++; bad_txn++;
                $display("FAIL rand_r_%0d: beats=%0d bad=%0d other=%0d rready_low=%0d last_at=%0d err=%b expected %0d 0 0 0 %0d 0",
                    t, ob, obad, othb, rb, li, rlast_err, int'(req_len[w]) + 1, int'(req_len[w]) + 1);
            end
            if (bad_txn > 4) return;
        end
        inst_if.arvalid = 1'b0;
        data_if.arvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_inst_only();
        test_data_uncached();
        test_simultaneous();
        test_back_to_back();
        test_ar_backpressure();
        test_missing_rlast();
        test_error_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
